// File: rtl/diff_frame_tx_if.sv
// diff_frame_tx_if: trigger/payload request plus encoded line and status
// returned by the differential-Manchester frame transmitter.
//   trigger_in : one-cycle start request
//   data_in    : DATA_WIDTH-bit payload, captured on an accepted trigger
//   data_out   : encoded serial line
//   busy_out   : frame in flight
//   done_out   : one-cycle pulse at frame completion
// master = requester side, slave = transmitter side.
interface diff_frame_tx_if #(
  parameter int unsigned DATA_WIDTH = 26
);
  logic                  trigger_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_out;
  logic                  busy_out;
  logic                  done_out;

  modport master (
    output trigger_in,
    output data_in,
    input  data_out,
    input  busy_out,
    input  done_out
  );

  modport slave (
    input  trigger_in,
    input  data_in,
    output data_out,
    output busy_out,
    output done_out
  );
endinterface

// File: rtl/diff_frame_tx.sv
// diff_frame_tx: differential-Manchester frame transmitter.
// Frame = SYNC_BITS periods of constant high, DATA_WIDTH payload bits MSB
// first, optional even-parity bit, one period of stop (low).
// Optional feature macro: DIFF_TX_PARITY_EN adds the parity bit period.
// Ports:
//   clk_in : system clock
//   rst_in : synchronous active-high reset
//   bus    : diff_frame_tx_if.slave (trigger_in, data_in -> data_out,
//            busy_out, done_out; all outputs registered)
module diff_frame_tx #(
  parameter int unsigned DATA_WIDTH  = 26,
  parameter int unsigned DATA_PERIOD = 20,
  parameter int unsigned SYNC_BITS   = 2
) (
  input logic           clk_in,
  input logic           rst_in,
  diff_frame_tx_if.slave bus
);

  localparam int unsigned BIT_MAX = (DATA_WIDTH > SYNC_BITS) ? DATA_WIDTH : SYNC_BITS;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
  localparam int unsigned CYC_W   = $clog2(DATA_PERIOD);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(DATA_PERIOD - 1);
  localparam logic [CYC_W-1:0] CYC_MID   = CYC_W'(DATA_PERIOD / 2 - 1);
  localparam logic [BIT_W-1:0] SYNC_LAST = BIT_W'(SYNC_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
`ifdef DIFF_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [CYC_W-1:0]      cyc_cnt, cyc_nxt, cyc_adv;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shreg, sh_nxt, sh_shift;
  logic                  line, line_nxt;
  logic                  busy, busy_nxt;
  logic                  done, done_nxt;
  logic                  bit_end;
`ifdef DIFF_TX_PARITY_EN
  logic                  par, par_nxt;
`endif

  // Period bookkeeping shared by every non-idle state.
  assign bit_end  = (cyc_cnt == CYC_LAST);
  assign cyc_adv  = bit_end ? '0 : cyc_cnt + CYC_W'(1);
  assign sh_shift = shreg << 1;

  // Registers: state, counters, shift register and the registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      line    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef DIFF_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= sh_nxt;
      line    <= line_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
`ifdef DIFF_TX_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

  // Next state plus next line level; line_nxt is the level for the
  // following cycle, so a bit-start decision uses the bit about to begin.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    line_nxt  = line;
    done_nxt  = 1'b0;
`ifdef DIFF_TX_PARITY_EN
    par_nxt   = par;
`endif

    case (state)
      IDLE: begin
        cyc_nxt  = '0;
        bit_nxt  = '0;
        line_nxt = 1'b0;
        if (bus.trigger_in) begin
          state_nxt = SYNC;
          sh_nxt    = bus.data_in;
          line_nxt  = 1'b1;
`ifdef DIFF_TX_PARITY_EN
          par_nxt   = ^bus.data_in;
`endif
        end
      end

      SYNC: begin
        cyc_nxt  = cyc_adv;
        line_nxt = 1'b1;
        if (bit_end) begin
          if (bit_cnt == SYNC_LAST) begin
            state_nxt = DATA;
            bit_nxt   = '0;
            // A 0 toggles at bit start, a 1 holds.
            line_nxt  = shreg[DATA_WIDTH-1] ? line : ~line;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end

      DATA: begin
        cyc_nxt = cyc_adv;
        if (cyc_cnt == CYC_MID) line_nxt = ~line;
        if (bit_end) begin
          sh_nxt = sh_shift;
          if (bit_cnt == DATA_LAST) begin
            bit_nxt = '0;
`ifdef DIFF_TX_PARITY_EN
            state_nxt = PARITY;
            line_nxt  = par ? line : ~line;
`else
            state_nxt = STOP;
            line_nxt  = 1'b0;
`endif
          end else begin
            bit_nxt  = bit_cnt + BIT_W'(1);
            line_nxt = sh_shift[DATA_WIDTH-1] ? line : ~line;
          end
        end
      end

`ifdef DIFF_TX_PARITY_EN
      PARITY: begin
        cyc_nxt = cyc_adv;
        if (cyc_cnt == CYC_MID) line_nxt = ~line;
        if (bit_end) begin
          state_nxt = STOP;
          line_nxt  = 1'b0;
        end
      end
`endif

      STOP: begin
        cyc_nxt  = cyc_adv;
        line_nxt = 1'b0;
        if (bit_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        line_nxt  = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.data_out = line;
  assign bus.busy_out = busy;
  assign bus.done_out = done;

endmodule

// File: tb/tb_diff_frame_tx.sv
// tb_diff_frame_tx: directed stimulus with a frame scoreboard. Stimulus pushes
// the expected payload and trigger cycle; a monitor captures each busy window,
// decodes the line and compares when done_out appears.
module tb_diff_frame_tx;
  localparam int DW = 26;
  localparam int DP = 20;
  localparam int SB = 2;
`ifdef DIFF_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB   = DW + P;
  localparam int F    = (SB + DW + P + 1) * DP;
  localparam int MAXS = F + 64;

  typedef struct {
    logic [DW-1:0] data;
    int            k;
  } exp_t;

  logic clk_in;
  logic rst_in;
  int   cyc_n;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  logic samp [0:MAXS-1];
  int   cnt;
  int   start_cyc;
  bit   in_frame;

  diff_frame_tx_if #(.DATA_WIDTH(DW)) bus_if ();

  diff_frame_tx #(
    .DATA_WIDTH (DW),
    .DATA_PERIOD(DP),
    .SYNC_BITS  (SB)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus_if)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial cyc_n = 0;
  always @(posedge clk_in) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic eval_frame();
    exp_t          e;
    logic [DW-1:0] dec;
    int            errs;
    int            ones;
    int            base;
    logic          prev, h1, h2;
`ifdef DIFF_TX_PARITY_EN
    logic          pbit;
    pbit = 1'b0;
`endif
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_frame: got a frame at cycle %0d expected none", cyc_n);
      return;
    end
    e = exp_q.pop_front();
    chk("start", start_cyc, e.k + 1);
    chk("busy_len", cnt, F);
    chk("done_at", cyc_n, e.k + 1 + F);
    ones = 0;
    for (int i = 0; i < SB * DP; i++) ones += int'(samp[i]);
    chk("sync", ones, SB * DP);
    prev = 1'b1;
    errs = 0;
    dec  = '0;
    for (int i = 0; i < NB; i++) begin
      base = SB * DP + i * DP;
      h1 = samp[base];
      h2 = samp[base + DP / 2];
      for (int j = 0; j < DP / 2; j++) begin
        if (samp[base + j] !== h1) errs++;
        if (samp[base + DP / 2 + j] !== h2) errs++;
      end
      if (h1 === h2) errs++;
      if (i < DW) dec = (dec << 1) | DW'(h1 === prev);
`ifdef DIFF_TX_PARITY_EN
      else pbit = (h1 === prev);
`endif
      prev = h2;
    end
    chk("data", 32'(dec), 32'(e.data));
    chk("code", errs, 0);
`ifdef DIFF_TX_PARITY_EN
    chk("parity", 32'(pbit), 32'(^e.data));
`endif
    ones = 0;
    for (int i = F - DP; i < F; i++) ones += int'(samp[i]);
    chk("stop", ones, 0);
  endtask

  // Monitor: capture each busy window; evaluate on the done pulse.
  initial begin
    in_frame = 1'b0;
    cnt = 0;
    start_cyc = 0;
  end

  always @(negedge clk_in) begin
    if (in_frame) begin
      if (bus_if.busy_out === 1'b1) begin
        if (cnt < MAXS) samp[cnt] = bus_if.data_out;
        cnt++;
      end else begin
        in_frame = 1'b0;
        if (bus_if.done_out === 1'b1) eval_frame();
      end
    end else if (bus_if.done_out === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_done: got done at cycle %0d expected none", cyc_n);
    end
    if (!in_frame && bus_if.busy_out === 1'b1) begin
      in_frame  = 1'b1;
      start_cyc = cyc_n;
      samp[0]   = bus_if.data_out;
      cnt       = 1;
    end
  end

  task automatic fire(input logic [DW-1:0] d, input bit expect_frame);
    exp_t e;
    bus_if.trigger_in = 1'b1;
    bus_if.data_in    = d;
    if (expect_frame) begin
      e.data = d;
      e.k    = cyc_n;
      exp_q.push_back(e);
    end
    @(negedge clk_in);
    bus_if.trigger_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus_if.done_out === 1'b1) return;
      @(negedge clk_in);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: got no done within %0d cycles expected done", budget);
  endtask

  task automatic run_frame(input logic [DW-1:0] d);
    fire(d, 1'b1);
    wait_done(F + 50);
    repeat (5) @(negedge clk_in);
  endtask

  initial begin
    exp_t e;
    n_cmp = 0;
    n_bad = 0;
    rst_in = 1'b1;
    bus_if.trigger_in = 1'b0;
    bus_if.data_in = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_data", 32'(bus_if.data_out), 0);
    chk("rst_busy", 32'(bus_if.busy_out), 0);
    chk("rst_done", 32'(bus_if.done_out), 0);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);

    run_frame(26'h0BE3219);
    run_frame(26'h0000000);
    run_frame(26'h3FFFFFF);

    // Trigger and new data mid-frame must be ignored.
    fire(26'h2AAAAAA, 1'b1);
    repeat (198) @(negedge clk_in);
    bus_if.trigger_in = 1'b1;
    bus_if.data_in    = 26'h1555555;
    @(negedge clk_in);
    bus_if.trigger_in = 1'b0;
    wait_done(F);
    repeat (50) @(negedge clk_in);
    chk("no_restart", 32'(bus_if.busy_out), 0);

    // Trigger held: next frame accepted in the done cycle.
    bus_if.data_in    = 26'h0C3A5F1;
    bus_if.trigger_in = 1'b1;
    e.data = 26'h0C3A5F1;
    e.k    = cyc_n;
    exp_q.push_back(e);
    @(negedge clk_in);
    wait_done(F + 50);
    e.k = cyc_n;
    exp_q.push_back(e);
    @(negedge clk_in);
    chk("b2b_start", 32'(bus_if.busy_out), 1);
    bus_if.trigger_in = 1'b0;
    wait_done(F + 50);
    repeat (5) @(negedge clk_in);

    // Mid-frame reset: abort without done, then a clean frame.
    fire(26'h1234567, 1'b0);
    repeat (298) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("abort_data", 32'(bus_if.data_out), 0);
    chk("abort_busy", 32'(bus_if.busy_out), 0);
    chk("abort_done", 32'(bus_if.done_out), 0);
    repeat (F + 20) @(negedge clk_in);
    run_frame(26'h1234567);

    run_frame(26'h0000001);

    repeat (20) @(negedge clk_in);
    chk("pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/diff_frame_tx.md
# diff_frame_tx

Parametrised differential-Manchester frame transmitter. It latches a DATA_WIDTH-bit word on a one-cycle trigger and serialises it MSB-first on a single line. The frame is a sync marker, the data bits, an optional parity bit and a stop period. It is the generalised successor to the fixed 26-bit serial link transmitter, and adds a busy/done handshake and a self-clocking line code so the receiver can recover timing.

## Interface
- DATA_WIDTH, 26, payload bits per frame (≥1).
- DATA_PERIOD, 20, clock cycles per bit period (even, ≥4).
- SYNC_BITS, 2, bit periods of constant-high sync marker (≥1).
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- trigger_in  input  1  start request; sampled every cycle.
- data_in  input  DATA_WIDTH  payload; captured only on an accepted trigger.
- data_out  output  1  encoded serial line, registered.
- busy_out  output  1  high while a frame is in flight, registered.
- done_out  output  1  one-cycle pulse at frame completion, registered.

## Operation
- States: IDLE, SYNC, DATA, PARITY, STOP.
- IDLE:
  - data_out=0, busy_out=0.
  - Accept when trigger_in=1 in IDLE: latch data_in into the shift register, go to SYNC.
- SYNC: data_out=1 for SYNC_BITS×DATA_PERIOD cycles. This is a deliberate code violation that marks frame start.
- DATA: DATA_WIDTH bits, MSB first, each DATA_PERIOD cycles, differential Manchester:
  - At bit start, toggle the line if the bit is 0; hold it if the bit is 1.
  - At DATA_PERIOD/2 into the bit, always toggle.
  - The line level entering the first bit is 1 (end of SYNC).
- PARITY (only with the macro): one bit period, same encoding, even parity over the payload.
- STOP: data_out=0 for one bit period, then IDLE with done_out=1 for that one cycle.
- Internal counters:
  - Cycle counter 0..DATA_PERIOD-1.
  - Bit counter sized $clog2(max(DATA_WIDTH,SYNC_BITS)+1).
  - All comparisons are unsigned; the counters never wrap past their terminal value.
- trigger_in while busy_out=1 is ignored. It does not restart, extend or corrupt the frame, and data_in changes are not sampled.
- A trigger in the same cycle as the done_out pulse is accepted, because the state is IDLE that cycle.
- rst_in, at any time including mid-frame:
  - Next cycle: IDLE, data_out=0, busy_out=0, done_out=0, counters and shift register cleared.
  - No done_out is issued for the aborted frame.

## Timing
- Reset values: data_out=0, busy_out=0, done_out=0.
- Frame length F = (SYNC_BITS + DATA_WIDTH + P + 1)×DATA_PERIOD cycles, where P=1 with parity, else 0.
- Trigger accepted at edge k:
  - busy_out and data_out=1 are visible from cycle k+1.
  - busy_out stays high exactly F cycles.
  - done_out is high on cycle k+1+F, the first cycle with busy_out=0.
- First data-bit boundary is at cycle k+1+SYNC_BITS×DATA_PERIOD.
- Bit i starts at that boundary + i×DATA_PERIOD; its mid-bit toggle is DATA_PERIOD/2 cycles later.
- Back-to-back frames: minimum trigger-to-trigger spacing is F+1 cycles.

## Configuration
- DIFF_TX_PARITY_EN defined: PARITY state compiled in, one extra even-parity bit period per frame, P=1.
- DIFF_TX_PARITY_EN undefined: no PARITY state or parity logic, STOP follows the last data bit, P=0.

## Test plan
All scenarios use DATA_WIDTH=26, DATA_PERIOD=20, SYNC_BITS=2; F=580 without parity, 600 with.
- Reset, then trigger with data_in=26'h0BE3219 -> sync high 40 cycles, decoded bits equal 0x0BE3219 MSB-first, busy 580 cycles, single done_out pulse at k+581.
- data_in=26'h0000000 -> data_out toggles every 10 cycles throughout DATA. data_in=26'h3FFFFFF -> toggles every 20 cycles (mid-bit only).
- data_in=26'h2AAAAAA, extra trigger and data_in change at cycle k+200 -> frame bits unchanged, done_out still at k+581, no second frame.
- Trigger held high continuously -> frames start at k and k+581; each frame is 580 busy cycles; exactly one done per frame.
- rst_in pulsed at k+300 -> data_out=0 and busy_out=0 next cycle, no done_out; a fresh trigger then yields a correct full frame.
- With DIFF_TX_PARITY_EN, data_in=26'h0000001 -> parity bit 1 encoded after bit 0, STOP after it, done_out at k+601. With 26'h3FFFFFF -> parity bit 0.
